// File: rtl/dir_key_queue_pkg.sv
// Shared direction codes, key indices and the axis-reversal helper for dir_key_queue.
package dir_pkg;

   typedef logic [2:0] dir_t;

   // bit2 = vertical axis; bit1 = down when vertical; bit0 = right when horizontal
   localparam dir_t DIR_UP    = 3'b100;
   localparam dir_t DIR_DOWN  = 3'b110;
   localparam dir_t DIR_LEFT  = 3'b000;
   localparam dir_t DIR_RIGHT = 3'b001;

   localparam int KEY_UP    = 3;
   localparam int KEY_DOWN  = 2;
   localparam int KEY_LEFT  = 1;
   localparam int KEY_RIGHT = 0;

   // Only canonical codes ever reach this: same axis but different code means opposite sense.
   function automatic logic is_reverse(input dir_t a, input dir_t b);
      return (a[2] == b[2]) && (a != b);
   endfunction

endpackage

// File: rtl/dir_key_queue_debounce.sv
// key_debounce: two-flop synchronizer plus stability counter for one active-low key.
// press pulses for one cycle in the cycle after the debounced level falls.
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst,
   input  logic key_n,
   output logic level,
   output logic press
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          level_q, level_d;
   logic          press_q, press_d;
   logic [CW-1:0] cnt_q,   cnt_d;

   always_comb begin
      sync1_d = key_n;
      sync2_d = sync1_q;
      level_d = level_q;
      press_d = 1'b0;
      cnt_d   = cnt_q;
      if (sync2_q == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         level_d = ~level_q;
         cnt_d   = '0;
         press_d = level_q;  // released -> pressed
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         level_q <= 1'b1;
         press_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         level_q <= level_d;
         press_q <= press_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level = level_q;
   assign press = press_q;

endmodule

// File: rtl/dir_key_queue.sv
// Debounced direction keys -> filtered turn FIFO -> one turn released per game tick.
// Define REVERSAL_FILTER_EN to also reject presses that reverse the reference direction.
module dir_key_queue
   import dir_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int DEPTH           = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [3:0]               key_n,
   input  logic                     tick,
   output logic [2:0]               dir_out,
   output logic                     dir_changed,
   output logic [$clog2(DEPTH):0]   q_count,
   output logic                     drop
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   typedef logic [PW-1:0] ptr_t;

   logic [3:0] press_w;
   logic [3:0] level_unused;

   for (genvar k = 0; k < 4; k++) begin : g_key
      key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
         .clk   (clk),
         .rst   (rst),
         .key_n (key_n[k]),
         .level (level_unused[k]),
         .press (press_w[k])
      );
   end

   dir_t          mem_q [DEPTH];
   dir_t          mem_d [DEPTH];
   ptr_t          wr_ptr_q, wr_ptr_d;
   ptr_t          rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   dir_t          dir_q, dir_d;
   logic          changed_q, changed_d;
   logic          drop_q, drop_d;

   dir_t req;
   logic req_v;
   dir_t ref_dir;
   ptr_t tail_ptr;
   logic rev_block;
   logic accept, push, pop, full;

   // Simultaneous presses: keep only the highest-priority key.
   always_comb begin
      req_v = 1'b1;
      req   = DIR_LEFT;
      if (press_w[KEY_UP])         req = DIR_UP;
      else if (press_w[KEY_DOWN])  req = DIR_DOWN;
      else if (press_w[KEY_LEFT])  req = DIR_LEFT;
      else if (press_w[KEY_RIGHT]) req = DIR_RIGHT;
      else                         req_v = 1'b0;
   end

   always_comb begin
      tail_ptr = wr_ptr_q - ptr_t'(1);
      ref_dir  = (count_q != '0) ? mem_q[tail_ptr] : dir_q;
`ifdef REVERSAL_FILTER_EN
      rev_block = is_reverse(req, ref_dir);
`else
      rev_block = 1'b0;
`endif
      full   = (count_q == DEPTH_C);
      pop    = tick && (count_q != '0);
      accept = req_v && (req != ref_dir) && !rev_block;
      // A full FIFO still takes the press when the same tick frees a slot.
      push   = accept && (!full || tick);
   end

   always_comb begin
      mem_d     = mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      dir_d     = dir_q;
      changed_d = 1'b0;
      drop_d    = accept && !push;
      if (push) begin
         mem_d[wr_ptr_q] = req;
         wr_ptr_d        = wr_ptr_q + ptr_t'(1);
      end
      if (pop) begin
         dir_d     = mem_q[rd_ptr_q];
         rd_ptr_d  = rd_ptr_q + ptr_t'(1);
         changed_d = 1'b1;
      end
      unique case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q     <= '{default: DIR_LEFT};
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         dir_q     <= DIR_LEFT;
         changed_q <= 1'b0;
         drop_q    <= 1'b0;
      end else begin
         mem_q     <= mem_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         dir_q     <= dir_d;
         changed_q <= changed_d;
         drop_q    <= drop_d;
      end
   end

   assign dir_out     = dir_q;
   assign dir_changed = changed_q;
   assign q_count     = count_q;
   assign drop        = drop_q;

endmodule
